// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship shot path: sequencer states,
// the two-digit BCD hit counter and its saturating add.
package battleship_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } seq_state_t;

  localparam int SHIP_SQUARES = 19;
  localparam int GRID_MAX     = 10;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Adds 0..9 to a BCD pair; any overflow past 99 clamps both digits to 9.
  function automatic bcd2_t bcd_add(input bcd2_t a, input logic [3:0] n);
    logic [4:0] sum;
    logic [4:0] tens;
    bcd2_t      r;
    sum  = {1'b0, a.ones} + {1'b0, n};
    tens = {1'b0, a.tens};
    if (sum > 5'd9) begin
      sum  = sum - 5'd10;
      tens = tens + 5'd1;
    end
    if (tens > 5'd9) begin
      r.tens = 4'd9;
      r.ones = 4'd9;
    end else begin
      r.tens = tens[3:0];
      r.ones = sum[3:0];
    end
    return r;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input bcd2_t v);
    return ({3'b000, v.tens} * 7'd10) + {3'b000, v.ones};
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Synchronises a raw active-low key and emits a one-cycle pulse on each press.
// Flops reset to the released level so reset release never looks like a press.
module key_edge_detect (
  input  logic clock,
  input  logic reset_L,
  input  logic i_key_l,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // NOTE: non-blocking assignments keep each flop sampling the previous stage's old value.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_l;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_prev & ~r_sync2;

endmodule

// File: rtl/shot_sequencer.sv
// Issues one scoring request per key press and keeps the game bookkeeping
// (shots, big bombs, BCD hit count, win/loss) from the scorer's results.
module shot_sequencer
  import battleship_pkg::*;
#(
  parameter int SHOTS     = 20,
  parameter int BIG_BOMBS = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       fire_L,
  input  logic       new_game,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       big_in,
  output logic [3:0] shot_x,
  output logic [3:0] shot_y,
  output logic       shot_big,
  output logic [1:0] big_left,
  output logic       score_req,
  input  logic       res_valid,
  input  logic       res_wrong,
  input  logic [3:0] res_num_hit,
  output logic [4:0] shots_left,
  output logic [3:0] hits_tens,
  output logic [3:0] hits_ones,
  output logic       err,
  output logic       game_over,
  output logic       won
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  seq_state_t       r_state, w_state_nxt;
  logic [3:0]       r_shot_x, w_shot_x_nxt;
  logic [3:0]       r_shot_y, w_shot_y_nxt;
  logic             r_shot_big, w_shot_big_nxt;
  logic [1:0]       r_big_left, w_big_left_nxt;
  logic             r_score_req, w_score_req_nxt;
  logic [4:0]       r_shots_left, w_shots_left_nxt;
  bcd2_t            r_hits, w_hits_nxt;
  logic             r_err, w_err_nxt;
  logic             r_game_over, w_game_over_nxt;
  logic             r_won, w_won_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;

  logic             w_fire_evt;
  bcd2_t            w_hits_sum;
  logic [6:0]       w_hits_bin;
  logic [4:0]       w_shots_dec;
  logic             w_reached;

  key_edge_detect u_fire (
    .clock   (clock),
    .reset_L (reset_L),
    .i_key_l (fire_L),
    .o_press (w_fire_evt)
  );

  assign w_hits_sum  = bcd_add(r_hits, res_num_hit);
  assign w_hits_bin  = bcd_to_bin(w_hits_sum);
  assign w_shots_dec = r_shots_left - 5'd1;
  assign w_reached   = (w_hits_bin >= 7'(SHIP_SQUARES));

  always_comb begin
    // NOTE: every next-value defaults to its current register first, so no path infers a latch.
    w_state_nxt      = r_state;
    w_shot_x_nxt     = r_shot_x;
    w_shot_y_nxt     = r_shot_y;
    w_shot_big_nxt   = r_shot_big;
    w_big_left_nxt   = r_big_left;
    w_score_req_nxt  = 1'b0;
    w_shots_left_nxt = r_shots_left;
    w_hits_nxt       = r_hits;
    w_err_nxt        = r_err;
    w_game_over_nxt  = r_game_over;
    w_won_nxt        = r_won;
    w_wait_cnt_nxt   = r_wait_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (w_fire_evt) begin
          w_shot_x_nxt    = x_in;
          w_shot_y_nxt    = y_in;
          w_shot_big_nxt  = big_in;
          w_score_req_nxt = 1'b1;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_wait_cnt_nxt = '0;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) begin
          if (res_wrong) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err_nxt        = 1'b0;
            w_hits_nxt       = w_hits_sum;
            w_shots_left_nxt = w_shots_dec;
            if (r_shot_big && (r_big_left != 2'd0)) w_big_left_nxt = r_big_left - 2'd1;
            if (w_reached || (w_shots_dec == 5'd0)) begin
              w_game_over_nxt = 1'b1;
              w_won_nxt       = w_reached;
              w_state_nxt     = S_DONE;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      S_DONE: begin
        // A press in the same cycle as new_game is dropped: DONE never looks at fire.
        if (new_game) begin
          w_shot_x_nxt     = '0;
          w_shot_y_nxt     = '0;
          w_shot_big_nxt   = 1'b0;
          w_big_left_nxt   = 2'(BIG_BOMBS);
          w_shots_left_nxt = 5'(SHOTS);
          w_hits_nxt       = '0;
          w_err_nxt        = 1'b0;
          w_game_over_nxt  = 1'b0;
          w_won_nxt        = 1'b0;
          w_wait_cnt_nxt   = '0;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= S_IDLE;
      r_shot_x     <= '0;
      r_shot_y     <= '0;
      r_shot_big   <= 1'b0;
      r_big_left   <= 2'(BIG_BOMBS);
      r_score_req  <= 1'b0;
      r_shots_left <= 5'(SHOTS);
      r_hits       <= '0;
      r_err        <= 1'b0;
      r_game_over  <= 1'b0;
      r_won        <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shot_x     <= w_shot_x_nxt;
      r_shot_y     <= w_shot_y_nxt;
      r_shot_big   <= w_shot_big_nxt;
      r_big_left   <= w_big_left_nxt;
      r_score_req  <= w_score_req_nxt;
      r_shots_left <= w_shots_left_nxt;
      r_hits       <= w_hits_nxt;
      r_err        <= w_err_nxt;
      r_game_over  <= w_game_over_nxt;
      r_won        <= w_won_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
    end
  end

  assign shot_x     = r_shot_x;
  assign shot_y     = r_shot_y;
  assign shot_big   = r_shot_big;
  assign big_left   = r_big_left;
  assign score_req  = r_score_req;
  assign shots_left = r_shots_left;
  assign hits_tens  = r_hits.tens;
  assign hits_ones  = r_hits.ones;
  assign err        = r_err;
  assign game_over  = r_game_over;
  assign won        = r_won;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer: a hand-driven scorer answers each request
// and the game counters are compared against hand-computed values.
module tb_shot_sequencer;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       fire_L = 1'b1;
  logic       new_game = 1'b0;
  logic [3:0] x_in = '0;
  logic [3:0] y_in = '0;
  logic       big_in = 1'b0;
  logic [3:0] shot_x, shot_y;
  logic       shot_big;
  logic [1:0] big_left;
  logic       score_req;
  logic       res_valid = 1'b0;
  logic       res_wrong = 1'b0;
  logic [3:0] res_num_hit = '0;
  logic [4:0] shots_left;
  logic [3:0] hits_tens, hits_ones;
  logic       err, game_over, won;

  int n_checks = 0;
  int n_fail   = 0;
  int req_total = 0;

  shot_sequencer #(.SHOTS(20), .BIG_BOMBS(2), .TIMEOUT(15)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .fire_L      (fire_L),
    .new_game    (new_game),
    .x_in        (x_in),
    .y_in        (y_in),
    .big_in      (big_in),
    .shot_x      (shot_x),
    .shot_y      (shot_y),
    .shot_big    (shot_big),
    .big_left    (big_left),
    .score_req   (score_req),
    .res_valid   (res_valid),
    .res_wrong   (res_wrong),
    .res_num_hit (res_num_hit),
    .shots_left  (shots_left),
    .hits_tens   (hits_tens),
    .hits_ones   (hits_ones),
    .err         (err),
    .game_over   (game_over),
    .won         (won)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (score_req === 1'b1) req_total <= req_total + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int sl, input int bl, input int tens,
                             input int ones, input int e, input int go, input int w);
    check({tag, "_shots_left"}, int'(shots_left), sl);
    check({tag, "_big_left"},   int'(big_left),   bl);
    check({tag, "_hits_tens"},  int'(hits_tens),  tens);
    check({tag, "_hits_ones"},  int'(hits_ones),  ones);
    check({tag, "_err"},        int'(err),        e);
    check({tag, "_game_over"},  int'(game_over),  go);
    check({tag, "_won"},        int'(won),        w);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_L = 1'b0;
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Presses the key and returns at the negedge where score_req is seen high.
  task automatic fire_and_wait(input logic [3:0] x, input logic [3:0] y, input logic b,
                               output bit seen);
    @(negedge clock);
    x_in   = x;
    y_in   = y;
    big_in = b;
    fire_L = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (score_req === 1'b1) seen = 1'b1;
    end
    fire_L = 1'b1;
    check("req_seen", int'(seen), 1);
  endtask

  task automatic respond(input int delay, input logic wrong, input logic [3:0] hit);
    repeat (delay) @(negedge clock);
    res_valid   = 1'b1;
    res_wrong   = wrong;
    res_num_hit = hit;
    @(negedge clock);
    res_valid   = 1'b0;
    res_wrong   = 1'b0;
    res_num_hit = '0;
    repeat (5) @(negedge clock);
  endtask

  task automatic shot(input logic [3:0] x, input logic [3:0] y, input logic b,
                      input int delay, input logic wrong, input logic [3:0] hit);
    bit seen;
    fire_and_wait(x, y, b, seen);
    if (seen) respond(delay, wrong, hit);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int r0;

    do_reset();
    check("rst_score_req", int'(score_req), 0);
    check("rst_shot_x", int'(shot_x), 0);
    check("rst_shot_big", int'(shot_big), 0);
    check_state("rst", 20, 2, 0, 0, 0, 0, 0);

    // Small shot answered two cycles after the request.
    r0 = req_total;
    fire_and_wait(4'd7, 4'd6, 1'b0, seen);
    check("small_shot_x", int'(shot_x), 7);
    check("small_shot_y", int'(shot_y), 6);
    check("small_shot_big", int'(shot_big), 0);
    respond(2, 1'b0, 4'd1);
    check("small_req_count", req_total - r0, 1);
    check_state("small", 19, 2, 0, 1, 0, 0, 0);

    // Big bombs until the inventory is gone, then a rejected big shot.
    do_reset();
    shot(4'd1, 4'd1, 1'b1, 1, 1'b0, 4'd9);
    check("big1_shot_big", int'(shot_big), 1);
    check_state("big1", 19, 1, 0, 9, 0, 0, 0);
    shot(4'd2, 4'd2, 1'b1, 1, 1'b0, 4'd9);
    check_state("big2", 18, 0, 1, 8, 0, 0, 0);
    shot(4'd3, 4'd3, 1'b1, 1, 1'b1, 4'd0);
    check_state("big3_wrong", 18, 0, 1, 8, 1, 0, 0);
    shot(4'd4, 4'd4, 1'b0, 1, 1'b0, 4'd0);
    check_state("miss", 17, 0, 1, 8, 0, 0, 0);

    // Timeout: err rises after exactly 15 WAIT cycles.
    fire_and_wait(4'd5, 4'd5, 1'b0, seen);
    repeat (15) @(negedge clock);
    check("timeout_err_early", int'(err), 0);
    @(negedge clock);
    check("timeout_err", int'(err), 1);
    repeat (5) @(negedge clock);
    check_state("timeout", 17, 0, 1, 8, 1, 0, 0);

    // Win from 18 hits with a 3-square result.
    shot(4'd9, 4'd8, 1'b0, 2, 1'b0, 4'd3);
    check_state("win", 16, 0, 2, 1, 0, 1, 1);
    r0 = req_total;
    @(negedge clock);
    x_in   = 4'd2;
    fire_L = 1'b0;
    repeat (20) @(negedge clock);
    fire_L = 1'b1;
    repeat (5) @(negedge clock);
    check("done_fire_ignored", req_total - r0, 0);
    check("done_shot_x_held", int'(shot_x), 9);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    @(negedge clock);
    check_state("new_game", 20, 2, 0, 0, 0, 0, 0);

    // Loss: twenty misses.
    for (int i = 0; i < 20; i++) begin
      shot(4'(i % 10), 4'd0, 1'b0, 1, 1'b0, 4'd0);
      if (i == 18) check_state("loss19", 1, 2, 0, 0, 0, 0, 0);
    end
    check_state("loss", 0, 2, 0, 0, 0, 1, 0);

    // Key held low: one request only (it then times out).
    do_reset();
    r0 = req_total;
    @(negedge clock);
    fire_L = 1'b0;
    repeat (100) @(negedge clock);
    fire_L = 1'b1;
    repeat (5) @(negedge clock);
    check("held_req_count", req_total - r0, 1);
    check("held_err", int'(err), 1);

    // Reset mid-WAIT, late result afterwards must be ignored.
    do_reset();
    fire_and_wait(4'd3, 4'd2, 1'b1, seen);
    @(negedge clock);
    reset_L = 1'b0;
    @(negedge clock);
    reset_L = 1'b1;
    r0 = req_total;
    @(negedge clock);
    res_valid   = 1'b1;
    res_num_hit = 4'd5;
    @(negedge clock);
    res_valid   = 1'b0;
    res_num_hit = '0;
    repeat (4) @(negedge clock);
    check("rstwait_shot_x", int'(shot_x), 0);
    check("rstwait_shot_big", int'(shot_big), 0);
    check("rstwait_req_count", req_total - r0, 0);
    check_state("rstwait", 20, 2, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_sequencer.md
# shot_sequencer

Issuing side of the shot-scoring interface. Captures the player's shot coordinates and bomb type on a debounced fire key press, presents one scoring request to the shot scorer, and waits for its result. On a result it updates the game bookkeeping: remaining big bombs, remaining shots, cumulative hits and win/loss. It sits between the board switches/KEY and the scorer, and drives the big-bombs-left count that the scorer validates against.

## Interface
Parameters:
- SHOTS, 20: shots per game; range 1..31.
- BIG_BOMBS, 2: big bombs per game; range 0..2, since big_left is 2 bits and the scorer treats 2'b11 as illegal.
- TIMEOUT, 15: number of WAIT cycles without res_valid before the shot is abandoned.

Ports:
- clock  in  1  system clock; the only clock.
- reset_L  in  1  asynchronous, active-low reset.
- fire_L  in  1  raw KEY[0], active-low, asynchronous to clock.
- new_game  in  1  synchronous pulse; in DONE it restarts the game.
- x_in  in  4  column switches.
- y_in  in  4  row switches.
- big_in  in  1  big-bomb select switch.
- shot_x  out  4  registered column presented to the scorer.
- shot_y  out  4  registered row presented to the scorer.
- shot_big  out  1  registered big-bomb flag.
- big_left  out  2  big bombs remaining.
- score_req  out  1  one-cycle request pulse.
- res_valid  in  1  scorer result strobe.
- res_wrong  in  1  scorer rejected the shot; qualified by res_valid.
- res_num_hit  in  4  squares hit, 0..9; qualified by res_valid.
- shots_left  out  5  shots remaining.
- hits_tens  out  4  BCD tens digit of the cumulative hit count.
- hits_ones  out  4  BCD ones digit of the cumulative hit count.
- err  out  1  last shot was rejected or timed out.
- game_over  out  1  high in DONE.
- won  out  1  high in DONE when the cumulative hit count is at least SHIP_SQUARES.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - On fire_evt, latch x_in, y_in and big_in into shot_x, shot_y and shot_big, then go to ISSUE.
  - fire_evt is ignored in every other state.
- ISSUE
  - score_req=1 for exactly this cycle, then go to WAIT.
  - A WAIT-cycle counter is cleared here.
- WAIT, when res_valid=1:
  - If res_wrong=1: err←1. No counter changes. Go to IDLE.
  - Otherwise:
    - err←0.
    - hits←hits+res_num_hit, held as a BCD pair and saturating at 99.
    - shots_left←shots_left−1.
    - If shot_big=1 and big_left>0, big_left←big_left−1.
    - Go to DONE if the new hits≥SHIP_SQUARES or the new shots_left=0; otherwise go to IDLE.
- WAIT, when the counter reaches TIMEOUT with no res_valid: err←1, no counter changes, go to IDLE.
- DONE
  - Outputs held.
  - new_game restores the reset values of every register except err, which is cleared, and returns to IDLE.
- res_valid is ignored outside WAIT.
- Big-bomb legality is not checked here. The request goes out with the current big_left, and the scorer returns res_wrong.
- Repeated hits on the same square are counted each time; the scorer keeps no board memory.
- BCD add: ones digit plus res_num_hit, with a carry into tens when the sum exceeds 9. If the tens digit would exceed 9, both digits clamp to 9.

## Timing
- fire_L passes through a 2-flop synchronizer plus an edge register.
- fire_evt is a single-cycle pulse on the synchronized 1→0 transition, 3 cycles after the falling edge.
- Holding the key does not generate repeat events.
- Shot registers load in the fire_evt cycle. score_req follows on the next cycle.
- The earliest result is accepted in the cycle after score_req. Counters update on the clock edge that samples res_valid.
- Reset values:
  - state IDLE
  - shot_x, shot_y, shot_big, score_req: 0
  - big_left = BIG_BOMBS
  - shots_left = SHOTS
  - hits_tens, hits_ones: 0
  - err, game_over, won: 0
  - synchronizer flops: 1, so no spurious event is generated at reset release.
- Reset asserted mid-WAIT aborts the shot immediately. A late res_valid after reset release is ignored because the state is IDLE.
- If new_game and fire_evt occur in the same DONE cycle, new_game wins and the fire is dropped.

## Structure
- battleship_pkg holds:
  - the state enum `seq_state_t`
  - `SHIP_SQUARES = 19`
  - `GRID_MAX = 10`
- Sub-module key_edge_detect contains the synchronizer and falling-edge pulse. It is reused for other KEY inputs.
- Everything else lives in one FSM plus datapath.

## Test plan
- Small shot, happy path:
  - Stimulus: press at x=7, y=6, big_in=0; scorer answers res_num_hit=1 two cycles after score_req.
  - Required: score_req pulses once; hits 01; shots_left 19; big_left 2; err 0.
- Big shot and inventory exhaustion:
  - Stimulus: two big shots, each answered with res_num_hit=9, then a third big shot answered with res_wrong.
  - Required: after the first two shots, hits 18 and big_left 0. After the third, err=1 and no counter changes.
- Timeout: no res_valid for 15 cycles → err=1, IDLE, counters unchanged.
- Win:
  - Stimulus: starting from hits 18, a shot answered with res_num_hit=3.
  - Required: hits 21; game_over=1 and won=1. A later fire is ignored; new_game restores SHOTS and BIG_BOMBS.
- Loss: 20 shots all answered res_num_hit=0 → game_over=1, won=0, shots_left 0.
- Reset and debounce:
  - Key held low for 100 cycles → exactly one score_req.
  - reset_L dropped during WAIT, with res_valid arriving after release → outputs stay at reset values.
